// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/bubble interlock for the T/D/E/M/W pipeline
// Inputs : clk, resetn (async active-low), D source regs/uses, E dest/load/redirect, m_busy
// Outputs: f/t/d/e/m_stall, t/d/e/w_bubble, sticky mem_timeout
// Macro PIPE_HAZARD_PERF_EN adds perf_mem_stall/perf_flush/perf_loaduse cycle counters
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        d_need_ra,
  input  logic        d_need_rb,
  input  logic [4:0]  d_ra,
  input  logic [4:0]  d_rb,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic [4:0]  e_rn,
  input  logic        e_redirect,
  input  logic        m_busy,
  output logic        f_stall,
  output logic        t_stall,
  output logic        d_stall,
  output logic        e_stall,
  output logic        m_stall,
  output logic        t_bubble,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        w_bubble,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_loaduse,
`endif
  output logic        mem_timeout
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] wcnt;
  logic load_use, busy_act, redir_act, flush_act, lu_act;
  assign load_use = e_wreg & e_m2reg & (e_rn != 5'd0) &
                    ((d_need_ra & (d_ra == e_rn)) | (d_need_rb & (d_rb == e_rn)));
  // resetn gates every action so outputs read 0 during reset regardless of inputs
  assign busy_act  = resetn & m_busy;
  assign redir_act = resetn & ~m_busy & e_redirect;
  assign flush_act = resetn & ~m_busy & ~e_redirect & (state == FLUSH);
  assign lu_act    = resetn & ~m_busy & ~e_redirect & (state == RUN) & load_use;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (redir_act) begin
      state_nx = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
      cnt_nx   = 4'(FLUSH_CYCLES - 1);
    end else if (flush_act) begin
      state_nx = (cnt == 4'd1) ? RUN : FLUSH;
      cnt_nx   = cnt - 4'd1;
    end
    f_stall  = busy_act | lu_act;
    t_stall  = busy_act | lu_act;
    d_stall  = busy_act | lu_act;
    e_stall  = busy_act;
    m_stall  = busy_act;
    w_bubble = busy_act;
    t_bubble = redir_act | flush_act;
    d_bubble = redir_act;
    e_bubble = lu_act;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      cnt         <= 4'd0;
      wcnt        <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wcnt  <= !m_busy ? 16'd0 : (wcnt == 16'(MAX_WAIT)) ? wcnt : wcnt + 16'd1;
      if (m_busy && wcnt == 16'(MAX_WAIT))
        mem_timeout <= 1'b1;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_mem_stall <= 32'd0;
      perf_flush     <= 32'd0;
      perf_loaduse   <= 32'd0;
    end else begin
      perf_mem_stall <= perf_mem_stall + 32'(busy_act);
      perf_flush     <= perf_flush + 32'(redir_act | flush_act);
      perf_loaduse   <= perf_loaduse + 32'(lu_act);
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench with directed hazard vectors
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic d_need_ra = 1'b0, d_need_rb = 1'b0, e_wreg = 1'b0, e_m2reg = 1'b0;
  logic [4:0] d_ra = 5'd0, d_rb = 5'd0, e_rn = 5'd0;
  logic e_redirect = 1'b0, m_busy = 1'b0;
  logic f_stall, t_stall, d_stall, e_stall, m_stall;
  logic t_bubble, d_bubble, e_bubble, w_bubble, mem_timeout;
  typedef struct {
    string      nm;
    logic [9:0] exp;
  } item_t;
  item_t q[$];
  int passed = 0, total = 0;
  localparam logic [9:0] ZERO = 10'b0000000000;
  localparam logic [9:0] LU   = 10'b1110000100;
  localparam logic [9:0] RED  = 10'b0000011000;
  localparam logic [9:0] FL   = 10'b0000010000;
  localparam logic [9:0] BUSY = 10'b1111100010;
  localparam logic [9:0] TO   = 10'b0000000001;
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_WAIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .d_need_ra(d_need_ra), .d_need_rb(d_need_rb), .d_ra(d_ra), .d_rb(d_rb),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .e_redirect(e_redirect), .m_busy(m_busy),
    .f_stall(f_stall), .t_stall(t_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .t_bubble(t_bubble), .d_bubble(d_bubble), .e_bubble(e_bubble), .w_bubble(w_bubble),
    .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t it;
      logic [9:0] act;
      it  = q.pop_front();
      act = {f_stall, t_stall, d_stall, e_stall, m_stall, t_bubble, d_bubble, e_bubble, w_bubble, mem_timeout};
      total++;
      if (act === it.exp) passed++;
      else $display("FAIL %s: got %b expected %b (fts,dts,e,m stall|t,d,e,w bubble|timeout)", it.nm, act, it.exp);
    end
  end
  task automatic step(input string nm, input logic rv, input logic lu, input logic [4:0] rn,
                      input logic redir, input logic busy, input logic [9:0] exp);
    @(posedge clk);
    #1;
    resetn     = rv;
    e_wreg     = lu;
    e_m2reg    = lu;
    d_need_ra  = lu;
    d_ra       = lu ? 5'd5 : 5'd0;
    e_rn       = rn;
    e_redirect = redir;
    m_busy     = busy;
    q.push_back('{nm, exp});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    step("reset_busy", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, ZERO);
    step("reset_lu", 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, ZERO);
    for (int i = 0; i < 10; i++) step("idle", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("load_use", 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, LU);
    step("load_use_r0", 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, ZERO);
    step("after_lu", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("busy_over_lu", 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, BUSY);
    step("busy_over_redir", 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, BUSY);
    step("idle2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("redir_c0", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RED);
    step("flush_c1_lu", 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, FL);
    step("flush_c2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    step("flush_c3", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("redir_a", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RED);
    step("flush_a1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    step("redir_restart", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RED);
    step("restart_f1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    step("restart_f2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    step("restart_done", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("redir_b", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RED);
    step("flush_b1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    for (int i = 0; i < 4; i++) step("flush_freeze", 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, BUSY);
    step("flush_b2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL);
    step("flush_b_done", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    for (int i = 1; i <= 12; i++)
      step(i <= 9 ? "busy_pre_to" : "busy_to", 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, i <= 9 ? BUSY : (BUSY | TO));
    step("to_sticky1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, TO);
    step("to_sticky2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, TO);
    step("redir_c", 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, RED | TO);
    step("flush_c1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FL | TO);
    step("reset_mid_flush", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("post_reset1", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("post_reset2", 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, ZERO);
    step("post_reset_lu", 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, LU);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
